cache_entry_ctrl: RTL and testbench
===================================

# cache_entry_ctrl

Write-back, write-allocate, direct-mapped cache controller: the initiator that drives the read and write ports of the 8-entry × 93-bit cache entry memory. It serves a 64-bit CPU-side request port and a 64-bit backing-memory port. It sits between a Cave sprite/tile fetch client and the DDR/SDRAM arbiter.

## Interface
Parameters:
- `ENTRIES`, 8: number of cache lines (power of two); index width `IW = log2(ENTRIES)`.
- `AW`, 30: CPU word-address width (64-bit words).
- `DW`, 64: data width.
- `TW`, `AW-IW` (27): tag width. Entry width is `2+TW+DW` (93).

Ports (all `AW`/`DW`/`TW`/`IW` widths are parameters):
- `clock`  in  1  sole clock; also drives the entry memory `R0_clk`/`W0_clk`.
- `reset`  in  1  synchronous, active-high.
- `cpu_rd`, `cpu_wr`  in  1  request strobes; held until `cpu_ack`.
- `cpu_addr`  in  AW  word address.
- `cpu_din`  in  DW  write data.
- `cpu_mask`  in  DW/8  byte enables for writes.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_dout`  out  DW  read data, valid while `cpu_ack` is high.
- `ent_rd_addr`, `ent_rd_en`  out  IW, 1  to entry memory R0.
- `ent_rd_data`  in  93  R0 data, valid the cycle after `ent_rd_en`.
- `ent_wr_addr`, `ent_wr_en`, `ent_wr_data`  out  IW, 1, 93  to entry memory W0.
- `mem_rd`, `mem_wr`  out  1  backing request; held until accepted.
- `mem_addr`  out  AW  backing address.
- `mem_dout`  out  DW  write-back data.
- `mem_wait`  in  1  high = request not accepted this cycle.
- `mem_valid`, `mem_din`  in  1, DW  read data return.

## Operation
- Entry layout: bit 92 = valid, 91 = dirty, [90:64] = tag, [63:0] = data.
- Address split: index = `cpu_addr[IW-1:0]`, tag = `cpu_addr[AW-1:IW]`.
- States: INIT, IDLE, LOOKUP, EVICT, FILL, FILL_WAIT.
- INIT: write all-zero entries to indices 0..7, one per cycle. Go to IDLE after index 7. Requests are not accepted here.
- IDLE: on `cpu_rd|cpu_wr`, latch the request, assert `ent_rd_en` with the index, go to LOOKUP. If both strobes are high, the request is treated as a write.
- LOOKUP: hit = valid && tag match.
  - Read hit: `cpu_ack`, `cpu_dout` = entry data, go to IDLE.
  - Write hit: write the byte-merged data with dirty=1, `cpu_ack`, go to IDLE.
  - Miss with valid && dirty: EVICT.
  - Otherwise (miss, clean or invalid): FILL.
- EVICT: `mem_wr` with `mem_addr = {old_tag, index}` and `mem_dout` = old data. Hold until `!mem_wait`, then go to FILL.
- FILL: `mem_rd` with `mem_addr = {tag, index}`. Hold until `!mem_wait`, then go to FILL_WAIT.
- FILL_WAIT: on `mem_valid`, write the entry {1, wr, tag, merged data}. For a read the data is `mem_din` unmerged. `cpu_ack` in the same cycle; `cpu_dout` = `mem_din`. Go to IDLE.
- Byte merge: byte i = `cpu_mask[i] ? cpu_din : old`.

## Timing
- Reset values: state = INIT, `cpu_ack`=0, `cpu_dout`=0, `mem_rd`=`mem_wr`=0, `mem_addr`=0, `mem_dout`=0, `ent_wr_en`=0, `ent_rd_en`=0. The INIT counter resets to 0.
- Hit latency: request seen in cycle N, `cpu_ack` in cycle N+1. Throughput is one request per 2 cycles.
- Miss latency: entry read (1) + eviction handshake + fill handshake + `mem_valid` wait.
- The CPU drops or changes its request in the cycle after `cpu_ack`. IDLE never samples the request in the ack cycle.
- A write in LOOKUP followed by a read of the same index from IDLE returns the new data, because the write commits on the edge closing LOOKUP.
- `mem_valid` outside FILL_WAIT is ignored.
- Reset mid-operation: requests drop in the next cycle, return to INIT, all entries are cleared, and late `mem_valid` is ignored.

## Structure
- Package `cave_cache_pkg` holds:
  - the entry field positions (VALID_BIT, DIRTY_BIT, TAG_LSB/MSB, DATA_MSB);
  - the default widths;
  - the state enum;
  - a `merge_bytes` function.
- No sub-module. The entry memory is instantiated by the parent and wired to the `ent_*` ports.

## Test plan
- After reset, 8 INIT cycles write 0 to indices 0..7. `cpu_rd` is held at addr 0x00000005 throughout and is not acked before cycle 9.
- Read miss to 0x00000013 (index 3, tag 2), clean:
  - `mem_rd` at addr 0x13;
  - `mem_din`=0x1122334455667788 with `mem_valid` → `cpu_ack`, `cpu_dout`=0x1122334455667788;
  - entry 3 = {1, 0, 2, data}.
- Read hit to 0x13 immediately after → `cpu_ack` one cycle after the request with the same data, no `mem_rd`.
- Write hit to 0x13 with `cpu_mask`=0x0F, `cpu_din`=0xFFFFFFFFAAAAAAAA → entry data = 0x11223344AAAAAAAA, dirty=1.
- Read of 0x1B (index 3, tag 3):
  - `mem_wr` addr 0x13, data 0x11223344AAAAAAAA, held 3 cycles under `mem_wait`;
  - then `mem_rd` addr 0x1B.
- Reset asserted in FILL_WAIT, then `mem_valid` pulsed → no `cpu_ack`, INIT re-runs, and the next read of 0x13 misses.

Source files
------------

// File: rtl/cave_cache_pkg.sv
// Shared constants, state encoding and byte-merge helper for the
// direct-mapped write-back cache entry controller.
package cave_cache_pkg;

    localparam int ENTRIES_D = 8;
    localparam int AW_D      = 30;
    localparam int DW_D      = 64;
    localparam int TW_D      = AW_D - $clog2(ENTRIES_D);

    // Entry layout: {valid, dirty, tag, data}
    localparam int DATA_MSB  = DW_D - 1;
    localparam int TAG_LSB   = DW_D;
    localparam int TAG_MSB   = TAG_LSB + TW_D - 1;
    localparam int DIRTY_BIT = TAG_MSB + 1;
    localparam int VALID_BIT = DIRTY_BIT + 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOOKUP,
        S_EVICT,
        S_FILL,
        S_FILL_WAIT
    } state_t;

    function automatic logic [DW_D-1:0] merge_bytes(
        input logic [DW_D-1:0]   old,
        input logic [DW_D-1:0]   din,
        input logic [DW_D/8-1:0] mask
    );
        logic [DW_D-1:0] res;
        res = old;
        for (int i = 0; i < DW_D/8; i++) begin
            if (mask[i]) res[i*8 +: 8] = din[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_entry_ctrl.sv
// Write-back, write-allocate, direct-mapped cache controller driving the
// read/write ports of an external entry memory and a backing-memory port.
module cache_entry_ctrl
    import cave_cache_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_D,
    parameter int AW      = AW_D,
    parameter int DW      = DW_D,
    parameter int IW      = $clog2(ENTRIES),
    parameter int TW      = AW - IW
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cpu_rd,
    input  logic               cpu_wr,
    input  logic [AW-1:0]      cpu_addr,
    input  logic [DW-1:0]      cpu_din,
    input  logic [DW/8-1:0]    cpu_mask,
    output logic               cpu_ack,
    output logic [DW-1:0]      cpu_dout,
    output logic [IW-1:0]      ent_rd_addr,
    output logic               ent_rd_en,
    input  logic [2+TW+DW-1:0] ent_rd_data,
    output logic [IW-1:0]      ent_wr_addr,
    output logic               ent_wr_en,
    output logic [2+TW+DW-1:0] ent_wr_data,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_dout,
    input  logic               mem_wait,
    input  logic               mem_valid,
    input  logic [DW-1:0]      mem_din
);

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    init_idx;
    logic             req_wr;
    logic [AW-1:0]    req_addr;
    logic [DW-1:0]    req_din;
    logic [DW/8-1:0]  req_mask;
    logic [TW-1:0]    old_tag;
    logic [DW-1:0]    old_data;

    logic [IW-1:0]    req_idx;
    logic [TW-1:0]    req_tag;
    logic             rd_valid;
    logic             rd_dirty;
    logic [TW-1:0]    rd_tag;
    logic [DW-1:0]    rd_data;
    logic             hit;
    logic [DW-1:0]    hit_merge;
    logic [DW-1:0]    fill_data;

    assign req_idx   = req_addr[IW-1:0];
    assign req_tag   = req_addr[AW-1:IW];
    assign rd_valid  = ent_rd_data[VALID_BIT];
    assign rd_dirty  = ent_rd_data[DIRTY_BIT];
    assign rd_tag    = ent_rd_data[TAG_MSB:TAG_LSB];
    assign rd_data   = ent_rd_data[DATA_MSB:0];
    assign hit       = rd_valid && (rd_tag == req_tag);
    assign hit_merge = merge_bytes(rd_data, req_din, req_mask);
    assign fill_data = req_wr ? merge_bytes(mem_din, req_din, req_mask)
                              : mem_din;

    // State register, init sweep counter, request and victim latches
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_INIT;
            init_idx <= '0;
            req_wr   <= 1'b0;
            req_addr <= '0;
            req_din  <= '0;
            req_mask <= '0;
            old_tag  <= '0;
            old_data <= '0;
        end else begin
            state <= state_nx;
            if (state == S_INIT) init_idx <= init_idx + 1'b1;
            if (state == S_IDLE && (cpu_rd || cpu_wr)) begin
                req_wr   <= cpu_wr;
                req_addr <= cpu_addr;
                req_din  <= cpu_din;
                req_mask <= cpu_mask;
            end
            if (state == S_LOOKUP) begin
                old_tag  <= rd_tag;
                old_data <= rd_data;
            end
        end
    end

    // Next-state and port drive; everything is forced quiet during reset
    always_comb begin
        state_nx    = state;
        cpu_ack     = 1'b0;
        cpu_dout    = '0;
        ent_rd_en   = 1'b0;
        ent_rd_addr = '0;
        ent_wr_en   = 1'b0;
        ent_wr_addr = '0;
        ent_wr_data = '0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_dout    = '0;
        unique case (state)
            S_INIT: begin
                ent_wr_en   = 1'b1;
                ent_wr_addr = init_idx;
                if (init_idx == IW'(ENTRIES - 1)) state_nx = S_IDLE;
            end
            S_IDLE: begin
                if (cpu_rd || cpu_wr) begin
                    ent_rd_en   = 1'b1;
                    ent_rd_addr = cpu_addr[IW-1:0];
                    state_nx    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    cpu_ack  = 1'b1;
                    state_nx = S_IDLE;
                    if (req_wr) begin
                        ent_wr_en   = 1'b1;
                        ent_wr_addr = req_idx;
                        ent_wr_data = {1'b1, 1'b1, req_tag, hit_merge};
                        cpu_dout    = hit_merge;
                    end else begin
                        cpu_dout = rd_data;
                    end
                end else if (rd_valid && rd_dirty) begin
                    state_nx = S_EVICT;
                end else begin
                    state_nx = S_FILL;
                end
            end
            S_EVICT: begin
                mem_wr   = 1'b1;
                mem_addr = {old_tag, req_idx};
                mem_dout = old_data;
                if (!mem_wait) state_nx = S_FILL;
            end
            S_FILL: begin
                mem_rd   = 1'b1;
                mem_addr = {req_tag, req_idx};
                if (!mem_wait) state_nx = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (mem_valid) begin
                    ent_wr_en   = 1'b1;
                    ent_wr_addr = req_idx;
                    ent_wr_data = {1'b1, req_wr, req_tag, fill_data};
                    cpu_ack     = 1'b1;
                    cpu_dout    = mem_din;
                    state_nx    = S_IDLE;
                end
            end
            default: state_nx = S_INIT;
        endcase
        if (reset) begin
            state_nx  = S_INIT;
            cpu_ack   = 1'b0;
            cpu_dout  = '0;
            ent_rd_en = 1'b0;
            ent_wr_en = 1'b0;
            mem_rd    = 1'b0;
            mem_wr    = 1'b0;
            mem_addr  = '0;
            mem_dout  = '0;
        end
    end

endmodule

// File: tb/tb_cache_entry_ctrl.sv
// Scoreboard bench for cache_entry_ctrl with entry-memory and
// backing-memory models and a flat reference memory for read data.
module tb_cache_entry_ctrl;

    localparam int AW = 30;
    localparam int DW = 64;
    localparam int IW = 3;
    localparam int TW = 27;
    localparam int EW = 2 + TW + DW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_rd = 1'b0;
    logic          cpu_wr = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_din = '0;
    logic [7:0]    cpu_mask = '0;
    logic          cpu_ack;
    logic [DW-1:0] cpu_dout;
    logic [IW-1:0] ent_rd_addr;
    logic          ent_rd_en;
    logic [EW-1:0] ent_rd_data = '0;
    logic [IW-1:0] ent_wr_addr;
    logic          ent_wr_en;
    logic [EW-1:0] ent_wr_data;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout;
    logic          mem_wait;
    logic          mem_valid = 1'b0;
    logic [DW-1:0] mem_din = '0;

    always #5 clock = ~clock;

    cache_entry_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_din     (cpu_din),
        .cpu_mask    (cpu_mask),
        .cpu_ack     (cpu_ack),
        .cpu_dout    (cpu_dout),
        .ent_rd_addr (ent_rd_addr),
        .ent_rd_en   (ent_rd_en),
        .ent_rd_data (ent_rd_data),
        .ent_wr_addr (ent_wr_addr),
        .ent_wr_en   (ent_wr_en),
        .ent_wr_data (ent_wr_data),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout),
        .mem_wait    (mem_wait),
        .mem_valid   (mem_valid),
        .mem_din     (mem_din)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input int a);
        if (a == 'h13) return 64'h1122334455667788;
        return {32'hB00C_0000 | 32'(a), ~32'(a)};
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Entry memory: registered read, data valid the cycle after ent_rd_en
    logic [EW-1:0] ent_mem [8];
    logic          ent_loaded = 1'b0;
    always @(posedge clock) begin
        if (!ent_loaded) begin
            for (int i = 0; i < 8; i++) ent_mem[i] <= {EW{1'b1}};
            ent_loaded <= 1'b1;
        end else begin
            if (ent_wr_en) ent_mem[ent_wr_addr] <= ent_wr_data;
        end
        if (ent_rd_en) ent_rd_data <= ent_mem[ent_rd_addr];
    end

    // Backing memory with configurable accept stall and read latency
    logic [63:0]   backing [64];
    logic          bk_loaded = 1'b0;
    int            wait_cfg = 0;
    int            wait_seen = 0;
    logic          suppress = 1'b0;
    int            rd_cnt = 0;
    int            wr_stall = 0;
    int            seq_n = 0;
    int            wr_seq = 0;
    int            rd_seq = 0;
    logic [AW-1:0] last_rd_addr = '0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [63:0]   last_wr_data = '0;
    logic          pend = 1'b0;
    logic [5:0]    pend_addr = '0;
    int            lat = 0;

    assign mem_wait = (mem_rd || mem_wr) && (wait_seen < wait_cfg);

    always @(posedge clock) begin
        mem_valid <= 1'b0;
        if (!bk_loaded) begin
            for (int i = 0; i < 64; i++) backing[i] <= init_word(i);
            bk_loaded <= 1'b1;
        end
        if ((mem_rd || mem_wr) && mem_wait) wait_seen <= wait_seen + 1;
        if (mem_wr && mem_wait) wr_stall <= wr_stall + 1;
        if ((mem_rd || mem_wr) && !mem_wait) begin
            wait_seen <= 0;
            seq_n     <= seq_n + 1;
        end
        if (mem_wr && !mem_wait) begin
            backing[mem_addr[5:0]] <= mem_dout;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_dout;
            wr_seq       <= seq_n;
        end
        if (mem_rd && !mem_wait) begin
            pend         <= 1'b1;
            pend_addr    <= mem_addr[5:0];
            lat          <= 1;
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= mem_addr;
            rd_seq       <= seq_n;
        end else if (pend && !suppress) begin
            if (lat == 0) begin
                mem_valid <= 1'b1;
                mem_din   <= backing[pend_addr];
                pend      <= 1'b0;
            end else begin
                lat <= lat - 1;
            end
        end
    end

    // Scoreboard: expectations pushed at request, popped on cpu_ack
    typedef struct {
        logic        rd;
        logic [63:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] refm [64];
    int          ack_total = 0;

    always @(negedge clock) begin
        if (cpu_ack) begin
            ack_total <= ack_total + 1;
            if (exp_q.size() == 0) begin
                chk("spurious_ack", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.rd) chk("rdata", cpu_dout, e.val);
            end
        end
    end

    task automatic push_exp(input logic wr, input logic [AW-1:0] a,
                            input logic [63:0] d, input logic [7:0] m);
        exp_t e;
        if (wr) begin
            for (int b = 0; b < 8; b++)
                if (m[b]) refm[a[5:0]][b*8 +: 8] = d[b*8 +: 8];
        end
        e.rd  = !wr;
        e.val = refm[a[5:0]];
        exp_q.push_back(e);
    endtask

    int req_cyc = 0;
    int ack_cyc = 0;

    task automatic wait_ack();
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        while (!got && n < 300) begin
            @(negedge clock);
            if (cpu_ack) begin
                got     = 1'b1;
                ack_cyc = cyc;
            end
            n++;
        end
        if (!got) chk("ack_timeout", 0, 1);
    endtask

    task automatic cpu_req(input logic wr, input logic both,
                           input logic [AW-1:0] a, input logic [63:0] d,
                           input logic [7:0] m);
        @(posedge clock);
        #1;
        cpu_rd   = !wr || both;
        cpu_wr   = wr;
        cpu_addr = a;
        cpu_din  = d;
        cpu_mask = m;
        req_cyc  = cyc;
        push_exp(wr, a, d, m);
        wait_ack();
        @(posedge clock);
        #1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    initial begin
        int n0;
        int s0;
        int a0;
        int rel0;
        for (int i = 0; i < 64; i++) refm[i] = init_word(i);

        // Read held through reset and INIT
        cpu_rd   = 1'b1;
        cpu_addr = 30'h5;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_strobes", {cpu_ack, mem_rd, mem_wr, ent_wr_en, ent_rd_en}, 0);
        chk("rst_cpu_dout", cpu_dout, 0);
        chk("rst_mem_bus", {mem_addr, mem_dout}, 0);
        reset = 1'b0;
        rel0  = cyc;
        push_exp(1'b0, 30'h5, '0, '0);
        wait_ack();
        chk("init_no_early_ack", (ack_cyc - rel0) >= 9, 1);
        @(posedge clock);
        #1;
        cpu_rd = 1'b0;
        for (int i = 0; i < 8; i++)
            if (i != 5) chk($sformatf("init_zero_%0d", i), ent_mem[i], 0);

        // Clean read miss
        n0 = rd_cnt;
        cpu_req(1'b0, 1'b0, 30'h13, '0, '0);
        chk("miss_rd_cnt", rd_cnt - n0, 1);
        chk("miss_rd_addr", last_rd_addr, 30'h13);
        chk("miss_entry3", ent_mem[3],
            {1'b1, 1'b0, 27'd2, 64'h1122334455667788});

        // Read hit
        n0 = rd_cnt;
        cpu_req(1'b0, 1'b0, 30'h13, '0, '0);
        chk("hit_latency", ack_cyc - req_cyc, 1);
        chk("hit_no_mem_rd", rd_cnt - n0, 0);

        // Write hit with byte merge
        cpu_req(1'b1, 1'b0, 30'h13, 64'hFFFFFFFFAAAAAAAA, 8'h0F);
        chk("whit_latency", ack_cyc - req_cyc, 1);
        chk("whit_data", ent_mem[3][63:0], 64'h11223344AAAAAAAA);
        chk("whit_dirty", ent_mem[3][91], 1);

        // Dirty miss: eviction stalled 3 cycles, then fill
        wait_cfg = 3;
        s0 = wr_stall;
        cpu_req(1'b0, 1'b0, 30'h1B, '0, '0);
        wait_cfg = 0;
        chk("evict_addr", last_wr_addr, 30'h13);
        chk("evict_data", last_wr_data, 64'h11223344AAAAAAAA);
        chk("evict_stall", wr_stall - s0, 3);
        chk("evict_fill_addr", last_rd_addr, 30'h1B);
        chk("evict_before_fill", wr_seq < rd_seq, 1);

        // Write miss with both strobes high, then read it back
        cpu_req(1'b1, 1'b1, 30'h2C, 64'hDEADBEEF00000000, 8'hF0);
        chk("wmiss_entry4", ent_mem[4],
            {1'b1, 1'b1, 27'd5, 32'hDEADBEEF, ~32'd44});
        n0 = rd_cnt;
        cpu_req(1'b0, 1'b0, 30'h2C, '0, '0);
        chk("wmiss_readback_hit", rd_cnt - n0, 0);

        // Reset while waiting for fill data; late mem_valid must be ignored
        suppress = 1'b1;
        n0 = rd_cnt;
        @(posedge clock);
        #1;
        cpu_rd   = 1'b1;
        cpu_addr = 30'h25;
        push_exp(1'b0, 30'h25, '0, '0);
        s0 = 0;
        while (rd_cnt == n0 && s0 < 100) begin
            @(negedge clock);
            s0++;
        end
        chk("rst_fill_issued", rd_cnt - n0, 1);
        @(posedge clock);
        #1;
        reset  = 1'b1;
        cpu_rd = 1'b0;
        exp_q.delete();
        a0 = ack_total;
        repeat (2) @(posedge clock);
        #1;
        suppress = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        chk("rst_no_ack", ack_total - a0, 0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("reinit_zero_%0d", i), ent_mem[i], 0);
        n0 = rd_cnt;
        cpu_req(1'b0, 1'b0, 30'h13, '0, '0);
        chk("post_rst_miss", rd_cnt - n0, 1);
        chk("post_rst_addr", last_rd_addr, 30'h13);

        // Random mix over a small address window
        for (int k = 0; k < 40; k++) begin
            logic [AW-1:0] a;
            logic          w;
            a        = AW'($urandom_range(0, 31));
            w        = 1'($urandom_range(0, 1));
            wait_cfg = $urandom_range(0, 2);
            cpu_req(w, 1'b0, a, {$urandom, $urandom}, 8'($urandom));
        end
        wait_cfg = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
